uart_rx: RTL
============

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL provide parameter: CLK_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200 baud); legal range 8..65535.
REQ-002 SHALL provide port: clk  input  1  single system clock; all state on rising edge.
REQ-003 SHALL provide port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL provide port: cpu_uart_rxd  input  1  raw serial line, idle high, asynchronous to clk.
REQ-005 SHALL provide port: rx_data  output  8  received byte, LSB first on line.
REQ-006 SHALL provide port: rx_valid  output  1  rx_data holds an unconsumed byte.
REQ-007 SHALL provide port: rx_ready  input  1  consumer (uart_controller) accepts byte when rx_valid & rx_ready.
REQ-008 SHALL provide port: framing_error  output  1  one-cycle pulse, stop bit sampled 0.
REQ-009 SHALL provide port: overrun  output  1  one-cycle pulse, completed byte dropped because buffer full.
REQ-010 SHALL provide port: parity_error  output  1  one-cycle pulse, parity mismatch (see Configuration).

Function
REQ-011 SHALL pass cpu_uart_rxd through a 2-flop synchronizer; all decisions use synchronized value rxd_s.
REQ-012 SHALL implement states IDLE, START, DATA, PARITY, STOP, BREAK with bit counter (3 bits) and cycle counter ($clog2(CLK_PER_BIT) bits).
REQ-013 IDLE: on rxd_s==0 SHALL clear cycle counter and go to START.
REQ-014 START: at count CLK_PER_BIT/2-1 SHALL resample; rxd_s==1 -> IDLE (glitch, no flags); rxd_s==0 -> DATA, counter cleared.
REQ-015 DATA: every CLK_PER_BIT cycles SHALL sample rxd_s into shift register LSB first; after 8th sample -> PARITY if enabled, else STOP.
REQ-016 STOP: after CLK_PER_BIT cycles SHALL sample; 1 -> deliver byte, IDLE; 0 -> framing_error pulse, byte discarded, BREAK.
REQ-017 BREAK: SHALL remain until rxd_s==1, then IDLE (no start detection during a held-low line).
REQ-018 Delivery SHALL occur one cycle after stop-bit sample: rx_data loaded, rx_valid set.
REQ-019 rx_valid SHALL stay 1 and rx_data stable until a cycle with rx_valid & rx_ready; then rx_valid clears next cycle.
REQ-020 Delivery while rx_valid==1 and rx_ready==0 SHALL pulse overrun, keep old byte, drop new.
REQ-021 Delivery in same cycle as a handshake SHALL load new byte, rx_valid stays 1, no overrun.
REQ-022 Receiver SHALL keep sampling new frames regardless of rx_valid (no backpressure on line).
REQ-023 Error pulses SHALL be exactly one clk wide; at most one error flag per frame.

Reset
REQ-024 Reset SHALL force: state IDLE, counters 0, synchronizer flops 1, shift register 0, rx_data 0x00, rx_valid 0, framing_error/overrun/parity_error 0.
REQ-025 Reset asserted mid-frame SHALL abandon frame; after release, a frame SHALL be recognized only from a fresh falling edge in IDLE.

Configuration
REQ-026 Macro UART_RX_PARITY_EN defined: frame = start, 8 data, even parity, stop (11 bits); PARITY state samples bit after CLK_PER_BIT; mismatch -> parity_error pulse at stop sample, byte discarded, STOP still checked for framing.
REQ-027 Macro UART_RX_PARITY_EN undefined: frame = 10 bits, PARITY state absent, parity_error tied 0.

Verification (CLK_PER_BIT=16)
REQ-028 Send 0xA5 with valid stop, rx_ready=1 -> rx_valid for exactly one cycle, rx_data=0xA5, 1 cycle after stop sample.
REQ-029 Low glitch of 4 cycles on idle line -> back to IDLE, no rx_valid, no flags.
REQ-030 Send 0x3C with stop=0, then line low 40 cycles, then high, then 0x81 -> framing_error once, only 0x81 delivered.
REQ-031 rx_ready=0, send 0x11 then 0x22 -> rx_data=0x11 held, overrun pulse at 0x22 delivery; raise rx_ready -> 0x11 consumed, rx_valid drops.
REQ-032 Back-to-back 0x55,0xAA with rx_ready pulsed exactly at 0xAA delivery cycle -> no overrun, rx_data=0xAA, rx_valid stays 1.
REQ-033 Reset asserted at 4th data bit of 0xFF, released, send 0x42 -> only 0x42 delivered; with UART_RX_PARITY_EN, 0x07 with parity bit 0 -> parity_error, no rx_valid.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 8-bit LSB-first UART receiver with 2-flop line sync; even parity when UART_RX_PARITY_EN is defined.
// Byte valid 1 clk after the stop-bit sample; no backpressure on the line, a byte arriving to a full buffer is dropped with an overrun pulse.
module uart_rx #(
    parameter int CLK_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cpu_uart_rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       framing_error,
    output logic       overrun,
    output logic       parity_error
);

    localparam int CW = $clog2(CLK_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLK_PER_BIT / 2 - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd4,
        BREAK = 3'd5
    } state_t;
`endif

    state_t          state_q, state_d;
    logic [1:0]      sync_q, sync_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      rx_data_q, rx_data_d;
    logic            rx_valid_q, rx_valid_d;
    logic            fe_q, fe_d;
    logic            ov_q, ov_d;
    logic            rxd_s;
    logic            deliver;
    logic            par_bad;

`ifdef UART_RX_PARITY_EN
    logic            par_bad_q, par_bad_d;
    logic            pe_q, pe_d;
    assign par_bad      = par_bad_q;
    assign parity_error = pe_q;
`else
    assign par_bad      = 1'b0;
    assign parity_error = 1'b0;
`endif

    assign rxd_s  = sync_q[1];
    assign sync_d = {sync_q[0], cpu_uart_rxd};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        fe_d       = 1'b0;
        ov_d       = 1'b0;
        deliver    = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d  = par_bad_q;
        pe_d       = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rxd_s) state_d = START;
            end
            START: begin
                // Mid-start-bit recheck rejects short low glitches.
                if (cnt_q == CNT_HALF) begin
                    cnt_d     = '0;
                    bit_cnt_d = '0;
                    state_d   = rxd_s ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d     = '0;
                    shift_d   = {rxd_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
`ifdef UART_RX_PARITY_EN
                    if (bit_cnt_q == 3'd7) state_d = PARITY;
`else
                    if (bit_cnt_q == 3'd7) state_d = STOP;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d     = '0;
                    par_bad_d = rxd_s ^ (^shift_q);
                    state_d   = STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    // Framing error wins over parity so a frame raises one flag at most.
                    if (!rxd_s) begin
                        fe_d    = 1'b1;
                        state_d = BREAK;
                    end else begin
                        state_d = IDLE;
`ifdef UART_RX_PARITY_EN
                        pe_d    = par_bad;
`endif
                        deliver = !par_bad;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            BREAK: begin
                if (rxd_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;
        if (deliver) begin
            if (rx_valid_q && !rx_ready) begin
                ov_d = 1'b1;
            end else begin
                rx_data_d  = shift_q;
                rx_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            sync_q     <= 2'b11;
            cnt_q      <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            fe_q       <= 1'b0;
            ov_q       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q  <= 1'b0;
            pe_q       <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            sync_q     <= sync_d;
            cnt_q      <= cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            fe_q       <= fe_d;
            ov_q       <= ov_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q  <= par_bad_d;
            pe_q       <= pe_d;
`endif
        end
    end

    assign rx_data       = rx_data_q;
    assign rx_valid      = rx_valid_q;
    assign framing_error = fe_q;
    assign overrun       = ov_q;

endmodule
